// File: rtl/apb_operand_bridge.sv
// APB3 slave in front of the operand banks A/B: bank writes, result/bank/control reads, engine start.
// Writes take zero wait states; reads take one wait state with registered prdata_o.
module apb_operand_bridge #(
  parameter int DATA_WIDTH = 32,
  parameter int BUS_WIDTH  = 64,
  parameter int ADDR_WIDTH = 32,
  localparam int MAX_DIM   = BUS_WIDTH / DATA_WIDTH,
  localparam int ROW_W     = (MAX_DIM > 1) ? $clog2(MAX_DIM) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  psel_i,
  input  logic                  penable_i,
  input  logic                  pwrite_i,
  input  logic [ADDR_WIDTH-1:0] paddr_i,
  input  logic [BUS_WIDTH-1:0]  pwdata_i,
  input  logic [MAX_DIM-1:0]    pstrb_i,
  output logic [BUS_WIDTH-1:0]  prdata_o,
  output logic                  pready_o,
  output logic                  pslverr_o,
  output logic                  a_we_o,
  output logic                  b_we_o,
  output logic [ROW_W-1:0]      op_addr_o,
  output logic [BUS_WIDTH-1:0]  op_data_o,
  output logic [MAX_DIM-1:0]    op_strb_o,
  input  logic [BUS_WIDTH-1:0]  a_rdata_i,
  input  logic [BUS_WIDTH-1:0]  b_rdata_i,
  input  logic [BUS_WIDTH-1:0]  res_rdata_i,
  input  logic                  busy_i,
  input  logic                  done_i,
  output logic                  start_o
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RDATA  = 2'd2;

  localparam logic [1:0] RG_CTRL = 2'b00;
  localparam logic [1:0] RG_A    = 2'b01;
  localparam logic [1:0] RG_B    = 2'b10;
  localparam logic [1:0] RG_RES  = 2'b11;

  logic [1:0]           state_q;
  logic [1:0]           region_q;
  logic [2:0]           row_q;
  logic [BUS_WIDTH-1:0] wdata_q;
  logic [MAX_DIM-1:0]   strb_q;
  logic                 write_q;
  logic                 err_q;
  logic                 done_q;

  logic                 setup;
  logic                 access;
  logic                 row_bad;
  logic                 start_req;
  logic                 err;
  logic                 wr_ok;
  logic                 done_clr;
  logic [BUS_WIDTH-1:0] rd_mux;

  logic unused_paddr;
  assign unused_paddr = ^{paddr_i[ADDR_WIDTH-1:8], paddr_i[2:0]};

  assign setup     = (state_q == ST_IDLE) && psel_i && !penable_i;
  // Dropping psel_i in ACCESS aborts: no handshake, no side effects.
  assign access    = (state_q == ST_ACCESS) && psel_i;
  assign row_bad   = (region_q != RG_CTRL) && (32'(row_q) >= MAX_DIM);
  assign start_req = write_q && (region_q == RG_CTRL) && strb_q[0] && wdata_q[0];
  assign err       = row_bad || (write_q && (region_q == RG_RES)) || (start_req && busy_i);
  assign wr_ok     = access && write_q && !err;
  assign done_clr  = wr_ok && (region_q == RG_CTRL) && strb_q[0] && wdata_q[2];

  assign a_we_o    = wr_ok && (region_q == RG_A);
  assign b_we_o    = wr_ok && (region_q == RG_B);
  assign pready_o  = (access && write_q) || (state_q == ST_RDATA);
  assign pslverr_o = (access && write_q && err) || ((state_q == ST_RDATA) && err_q);
  assign op_addr_o = row_q[ROW_W-1:0];
  assign op_data_o = wdata_q;
  assign op_strb_o = strb_q;

  always_comb begin
    rd_mux = '0;
    case (region_q)
      RG_CTRL: rd_mux[2:0] = {done_q, busy_i, 1'b0};
      RG_A:    rd_mux = a_rdata_i;
      RG_B:    rd_mux = b_rdata_i;
      default: rd_mux = res_rdata_i;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      region_q <= '0;
      row_q    <= '0;
      wdata_q  <= '0;
      strb_q   <= '0;
      write_q  <= 1'b0;
      err_q    <= 1'b0;
      prdata_o <= '0;
      start_o  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      start_o <= wr_ok && start_req;
      // A done_i pulse coincident with a clear must not be lost.
      if (done_i)        done_q <= 1'b1;
      else if (done_clr) done_q <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (setup) begin
            state_q  <= ST_ACCESS;
            region_q <= paddr_i[7:6];
            row_q    <= paddr_i[5:3];
            wdata_q  <= pwdata_i;
            strb_q   <= pstrb_i;
            write_q  <= pwrite_i;
          end
        end
        ST_ACCESS: begin
          if (access && !write_q) begin
            state_q  <= ST_RDATA;
            err_q    <= err;
            prdata_o <= err ? '0 : rd_mux;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_operand_bridge.sv
// Bench for apb_operand_bridge: directed scenarios plus a randomized bank/result traffic run against a memory model.
module tb_apb_operand_bridge;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [31:0] paddr = '0;
  logic [63:0] pwdata = '0;
  logic [1:0]  pstrb = '0;
  logic [63:0] prdata;
  logic        pready, pslverr, a_we, b_we, start;
  logic [0:0]  op_addr;
  logic [63:0] op_data;
  logic [1:0]  op_strb;
  logic [63:0] a_rdata, b_rdata, res_rdata;
  logic        busy = 1'b0, done_i = 1'b0;

  always #5 clk = ~clk;

  apb_operand_bridge dut (
    .clk_i(clk), .rst_ni(rst_n), .psel_i(psel), .penable_i(penable), .pwrite_i(pwrite),
    .paddr_i(paddr), .pwdata_i(pwdata), .pstrb_i(pstrb), .prdata_o(prdata),
    .pready_o(pready), .pslverr_o(pslverr), .a_we_o(a_we), .b_we_o(b_we),
    .op_addr_o(op_addr), .op_data_o(op_data), .op_strb_o(op_strb),
    .a_rdata_i(a_rdata), .b_rdata_i(b_rdata), .res_rdata_i(res_rdata),
    .busy_i(busy), .done_i(done_i), .start_o(start)
  );

  // Bank storage the DUT writes into; reads are combinational on op_addr.
  logic [63:0] bank_a [2];
  logic [63:0] bank_b [2];
  logic [63:0] res_mem [2];
  assign a_rdata   = bank_a[op_addr];
  assign b_rdata   = bank_b[op_addr];
  assign res_rdata = res_mem[op_addr];

  always @(posedge clk) begin
    for (int e = 0; e < 2; e++) begin
      if (a_we && op_strb[e]) bank_a[op_addr][e*32 +: 32] <= op_data[e*32 +: 32];
      if (b_we && op_strb[e]) bank_b[op_addr][e*32 +: 32] <= op_data[e*32 +: 32];
    end
  end

  int a_we_cnt = 0, b_we_cnt = 0, start_cnt = 0;
  always @(negedge clk) begin
    a_we_cnt  += int'(a_we);
    b_we_cnt  += int'(b_we);
    start_cnt += int'(start);
  end

  // Reference model: expected bank contents
  logic [63:0] ref_a [2];
  logic [63:0] ref_b [2];

  int checks = 0, failures = 0;
  int acc_op_addr;

  function automatic logic [31:0] addr_of(input int region, input int row);
    return 32'((region << 6) | (row << 3));
  endfunction

  function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] nw, input logic [1:0] s);
    logic [63:0] r;
    r = old;
    if (s[0]) r[31:0]  = nw[31:0];
    if (s[1]) r[63:32] = nw[63:32];
    return r;
  endfunction

  // Runs one APB transfer starting at a negedge; ends at a negedge with the bus idle.
  task automatic apb(input bit wr, input logic [31:0] addr, input logic [63:0] data,
                     input logic [1:0] strb, input bit done_pulse,
                     output logic [63:0] rd, output logic err, output int waits);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data; pstrb = strb;
    @(negedge clk);
    penable = 1'b1;
    if (done_pulse) done_i = 1'b1;
    acc_op_addr = int'(op_addr);
    waits = 0;
    while (pready !== 1'b1) begin
      if (waits >= 8) begin
        failures++;
        $display("FAIL pready_timeout: no pready after %0d cycles, need <= 1", waits);
        break;
      end
      @(negedge clk);
      waits++;
    end
    rd  = prdata;
    err = pslverr;
    @(negedge clk);
    psel = 1'b0; penable = 1'b0; done_i = 1'b0;
  endtask

  task automatic test_reset();
    logic [63:0] rd; logic err; int w;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({prdata, pready, pslverr, a_we, b_we, start, op_addr, op_data, op_strb} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: prdata=%h rdy=%b err=%b awe=%b bwe=%b start=%b, need all 0",
               prdata, pready, pslverr, a_we, b_we, start);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({prdata, pready, start} !== '0) begin
      failures++;
      $display("FAIL reset_idle: prdata=%h rdy=%b start=%b, need 0", prdata, pready, start);
    end
    apb(1'b0, addr_of(0, 0), '0, '0, 1'b0, rd, err, w);
    checks++;
    if (rd !== 64'h0 || err !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl: got %h err=%b, need 0 err=0", rd, err);
    end
  endtask

  task automatic test_write_read_a();
    logic [63:0] rd; logic err; int w, a0;
    a0 = a_we_cnt;
    apb(1'b1, addr_of(1, 1), 64'hDEADBEEF_00000001, 2'b11, 1'b0, rd, err, w);
    ref_a[1] = 64'hDEADBEEF_00000001;
    checks++;
    if (w !== 0 || err !== 1'b0 || acc_op_addr !== 1 || a_we_cnt - a0 !== 1) begin
      failures++;
      $display("FAIL write_a: waits=%0d err=%b op_addr=%0d we_cycles=%0d, need 0 0 1 1",
               w, err, acc_op_addr, a_we_cnt - a0);
    end
    apb(1'b0, addr_of(1, 1), '0, '0, 1'b0, rd, err, w);
    checks++;
    if (rd !== ref_a[1] || w !== 1 || err !== 1'b0) begin
      failures++;
      $display("FAIL read_a: got %h waits=%0d err=%b, need %h waits=1 err=0", rd, w, err, ref_a[1]);
    end
  endtask

  task automatic test_strobe();
    logic [63:0] rd; logic err; int w, b0;
    apb(1'b1, addr_of(2, 0), 64'hAAAAAAAA_BBBBBBBB, 2'b11, 1'b0, rd, err, w);
    apb(1'b1, addr_of(2, 0), 64'h11111111_22222222, 2'b01, 1'b0, rd, err, w);
    ref_b[0] = 64'hAAAAAAAA_22222222;
    apb(1'b0, addr_of(2, 0), '0, '0, 1'b0, rd, err, w);
    checks++;
    if (rd !== 64'hAAAAAAAA_22222222) begin
      failures++;
      $display("FAIL strobe_partial: got %h, need aaaaaaaa22222222", rd);
    end
    b0 = b_we_cnt;
    apb(1'b1, addr_of(2, 0), 64'h55555555_66666666, 2'b00, 1'b0, rd, err, w);
    checks++;
    if (err !== 1'b0 || w !== 0) begin
      failures++;
      $display("FAIL strobe_zero_resp: err=%b waits=%0d, need 0 0", err, w);
    end
    apb(1'b0, addr_of(2, 0), '0, '0, 1'b0, rd, err, w);
    checks++;
    if (rd !== ref_b[0]) begin
      failures++;
      $display("FAIL strobe_zero_data: got %h, need %h (we_cycles=%0d)", rd, ref_b[0], b_we_cnt - b0);
    end
  endtask

  task automatic test_errors();
    logic [63:0] rd; logic err; int w, a0, b0;
    a0 = a_we_cnt; b0 = b_we_cnt;
    apb(1'b1, addr_of(1, 5), 64'h1234, 2'b11, 1'b0, rd, err, w);
    checks++;
    if (err !== 1'b1 || w !== 0) begin
      failures++;
      $display("FAIL err_row_write: err=%b waits=%0d, need 1 0", err, w);
    end
    apb(1'b1, addr_of(3, 0), 64'h5678, 2'b11, 1'b0, rd, err, w);
    checks++;
    if (err !== 1'b1 || a_we_cnt != a0 || b_we_cnt != b0) begin
      failures++;
      $display("FAIL err_res_write: err=%b awe=%0d bwe=%0d, need 1 0 0", err, a_we_cnt - a0, b_we_cnt - b0);
    end
    apb(1'b0, addr_of(2, 7), '0, '0, 1'b0, rd, err, w);
    checks++;
    if (err !== 1'b1 || rd !== 64'h0 || w !== 1) begin
      failures++;
      $display("FAIL err_row_read: got %h err=%b waits=%0d, need 0 1 1", rd, err, w);
    end
  endtask

  task automatic test_start();
    logic [63:0] rd; logic err; int w, s0;
    s0 = start_cnt;
    apb(1'b1, addr_of(0, 0), 64'h1, 2'b01, 1'b0, rd, err, w);
    repeat (3) @(negedge clk);
    checks++;
    if (start_cnt - s0 !== 1 || err !== 1'b0) begin
      failures++;
      $display("FAIL start_pulse: start cycles=%0d err=%b, need 1 0", start_cnt - s0, err);
    end
    busy = 1'b1;
    s0 = start_cnt;
    apb(1'b1, addr_of(0, 0), 64'h1, 2'b01, 1'b0, rd, err, w);
    repeat (3) @(negedge clk);
    checks++;
    if (start_cnt - s0 !== 0 || err !== 1'b1) begin
      failures++;
      $display("FAIL start_busy: start cycles=%0d err=%b, need 0 1", start_cnt - s0, err);
    end
    apb(1'b0, addr_of(0, 0), '0, '0, 1'b0, rd, err, w);
    checks++;
    if (rd !== 64'h2) begin
      failures++;
      $display("FAIL ctrl_busy_read: got %h, need 2", rd);
    end
    busy = 1'b0;
  endtask

  task automatic test_done();
    logic [63:0] rd; logic err; int w;
    done_i = 1'b1;
    @(negedge clk);
    done_i = 1'b0;
    @(negedge clk);
    apb(1'b0, addr_of(0, 0), '0, '0, 1'b0, rd, err, w);
    checks++;
    if (rd !== 64'h4) begin
      failures++;
      $display("FAIL done_set: got %h, need 4", rd);
    end
    apb(1'b1, addr_of(0, 0), 64'h4, 2'b01, 1'b1, rd, err, w);
    apb(1'b0, addr_of(0, 0), '0, '0, 1'b0, rd, err, w);
    checks++;
    if (rd !== 64'h4) begin
      failures++;
      $display("FAIL done_set_wins: got %h, need 4", rd);
    end
    apb(1'b1, addr_of(0, 0), 64'h4, 2'b01, 1'b0, rd, err, w);
    apb(1'b0, addr_of(0, 0), '0, '0, 1'b0, rd, err, w);
    checks++;
    if (rd !== 64'h0) begin
      failures++;
      $display("FAIL done_clear: got %h, need 0", rd);
    end
  endtask

  task automatic test_abort();
    logic [63:0] rd; logic err; int w, s0;
    s0 = start_cnt;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = addr_of(1, 0);
    pwdata = 64'hFFFF_FFFF_FFFF_FFFF; pstrb = 2'b11;
    @(negedge clk);
    psel = 1'b0;
    #1;
    checks++;
    if (pready !== 1'b0 || a_we !== 1'b0) begin
      failures++;
      $display("FAIL abort_resp: pready=%b a_we=%b, need 0 0", pready, a_we);
    end
    @(negedge clk);
    apb(1'b0, addr_of(1, 0), '0, '0, 1'b0, rd, err, w);
    checks++;
    if (rd !== ref_a[0] || start_cnt != s0) begin
      failures++;
      $display("FAIL abort_nowrite: got %h, need %h", rd, ref_a[0]);
    end
  endtask

  task automatic test_reset_mid();
    logic [63:0] rd; logic err; int w;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = addr_of(1, 1);
    @(negedge clk);
    penable = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (pready !== 1'b0 || pslverr !== 1'b0 || prdata !== 64'h0) begin
      failures++;
      $display("FAIL reset_mid: pready=%b pslverr=%b prdata=%h, need 0 0 0", pready, pslverr, prdata);
    end
    psel = 1'b0; penable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    apb(1'b0, addr_of(1, 1), '0, '0, 1'b0, rd, err, w);
    checks++;
    if (rd !== ref_a[1] || w !== 1 || err !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_next: got %h waits=%0d err=%b, need %h 1 0", rd, w, err, ref_a[1]);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] rd; logic err; int w;
    apb(1'b1, addr_of(1, 0), 64'h0102030405060708, 2'b11, 1'b0, rd, err, w);
    apb(1'b1, addr_of(2, 1), 64'h1112131415161718, 2'b10, 1'b0, rd, err, w);
    ref_a[0] = 64'h0102030405060708;
    ref_b[1] = merge(ref_b[1], 64'h1112131415161718, 2'b10);
    apb(1'b0, addr_of(1, 0), '0, '0, 1'b0, rd, err, w);
    checks++;
    if (rd !== ref_a[0]) begin
      failures++;
      $display("FAIL b2b_a: got %h, need %h", rd, ref_a[0]);
    end
    apb(1'b0, addr_of(2, 1), '0, '0, 1'b0, rd, err, w);
    checks++;
    if (rd !== ref_b[1]) begin
      failures++;
      $display("FAIL b2b_b: got %h, need %h", rd, ref_b[1]);
    end
  endtask

  task automatic test_random();
    logic [63:0] rd, data, exp; logic err; int w, a0, b0;
    bit wr, exp_err; int region, row; logic [1:0] strb;
    for (int i = 0; i < 60; i++) begin
      wr = 1'($urandom_range(0, 1));
      region = $urandom_range(1, 3);
      row = $urandom_range(0, 2);
      data = {$urandom, $urandom};
      strb = 2'($urandom_range(0, 3));
      exp_err = (row >= 2) || (wr && region == 3);
      a0 = a_we_cnt; b0 = b_we_cnt;
      apb(wr, addr_of(region, row), data, strb, 1'b0, rd, err, w);
      checks++;
      if (err !== exp_err || w !== (wr ? 0 : 1)) begin
        failures++;
        $display("FAIL rand_resp[%0d]: err=%b waits=%0d, need %b %0d", i, err, w, exp_err, wr ? 0 : 1);
      end
      checks++;
      if (a_we_cnt - a0 !== ((wr && !exp_err && region == 1) ? 1 : 0) ||
          b_we_cnt - b0 !== ((wr && !exp_err && region == 2) ? 1 : 0)) begin
        failures++;
        $display("FAIL rand_we[%0d]: a=%0d b=%0d region=%0d row=%0d", i, a_we_cnt - a0, b_we_cnt - b0, region, row);
      end
      if (wr && !exp_err) begin
        if (region == 1) ref_a[row] = merge(ref_a[row], data, strb);
        else             ref_b[row] = merge(ref_b[row], data, strb);
      end
      if (!wr) begin
        exp = exp_err ? 64'h0 : (region == 1) ? ref_a[row] : (region == 2) ? ref_b[row] : res_mem[row];
        checks++;
        if (rd !== exp) begin
          failures++;
          $display("FAIL rand_read[%0d]: got %h, need %h", i, rd, exp);
        end
      end
    end
  endtask

  initial begin
    for (int r = 0; r < 2; r++) begin
      bank_a[r] = '0; bank_b[r] = '0;
      ref_a[r] = '0;  ref_b[r] = '0;
      res_mem[r] = {$urandom, $urandom};
    end
    @(negedge clk);
    test_reset();
    test_write_read_a();
    test_strobe();
    test_errors();
    test_start();
    test_done();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
